lsmitll_pattern_src_sync: RTL
=============================

Name: lsmitll_pattern_src_sync

Overview:
- Parametrised successor to the single-bit clocked constant-0 source cell.
- Generates WIDTH clocked output channels per clock edge in one of four modes: constant 0, constant 1, repeating programmable pattern, or one-shot pattern.
- The pattern memory holds DEPTH words of WIDTH bits.
- Used as a stimulus/tie-off source in clocked-cell test harnesses and as a programmable sync source in cell-library netlists.

Parameters:
WIDTH, 4, number of output channels (bits per pattern word), >=1
DEPTH, 8, pattern memory entries, >=2
ADDR_W, $clog2(DEPTH), address/pointer width (derived, do not override)
LEN_W, $clog2(DEPTH+1), pattern-length field width (derived)

Ports:
clk  input  1  clock, all state updates on rising edge
rst_n  input  1  asynchronous active-low reset
mode  input  2  00=always0, 01=always1, 10=repeat pattern, 11=one-shot pattern
len  input  LEN_W  active pattern length in words
start  input  1  one-shot trigger, sampled only in mode 11
wr_en  input  1  pattern memory write enable
wr_addr  input  ADDR_W  write address
wr_data  input  WIDTH  write data
q  output  WIDTH  registered channel outputs
busy  output  1  high while a one-shot playback is in progress
done  output  1  one-cycle pulse after the last one-shot word is output

Behaviour:
- Reset (rst_n=0, asynchronous, any time including mid-playback):
  - q=0, busy=0, done=0, ptr=0, prev_mode=00.
  - All memory words cleared to 0.
  - On release, the first active edge operates normally.
- Effective length: L = 1 if len==0; L = DEPTH if len>DEPTH; otherwise L = len.
- All outputs are registered. q changes only on rising clk edges (or on reset).
- Mode change: if mode != prev_mode at an edge, ptr is forced to 0 for that edge's selection. prev_mode <= mode on every edge.
- Mode 00: q<=0; ptr<=0; busy<=0.
- Mode 01: q<={WIDTH{1}}; ptr<=0; busy<=0.
- Mode 10 (repeat):
  - q<=mem[ptr].
  - ptr<=(ptr==L-1)?0:ptr+1.
  - First edge in mode 10 outputs mem[0]. The sequence is mem[0..L-1] repeating with no gap.
- Mode 11 (one-shot), states IDLE, PLAY:
  - IDLE: q<=0. If start=1: q<=mem[0], busy<=1, go to PLAY. If L==1, treat mem[0] as the last word (see below).
  - PLAY: advance ptr by one per edge; q<=mem[ptr].
  - Last word: on the edge after mem[L-1] is output, q<=0, busy<=0, done<=1 for exactly one cycle, ptr<=0, go to IDLE.
  - start while busy=1 is ignored.
  - start on the same edge as a done pulse is honoured: a new playback begins, and done and busy are both high that cycle.
  - Leaving mode 11 during PLAY aborts playback: busy<=0, no done pulse.
- done is 0 in every mode other than 11.
- Memory write:
  - Synchronous, on any edge with wr_en=1, in any mode.
  - Read-before-write: if wr_addr equals the word read on the same edge, q gets the old data. The new data is visible on the next read.
- len may change at any time and takes effect immediately.
  - If ptr>=new L, the next edge wraps ptr to 0 (mode 10), or ends playback as the last word (mode 11).
- No X propagation: q never shows X after reset release.

Test Plan:
- Reset/const: assert rst_n=0 mid-run, then release with mode=00 -> q=4'h0 every cycle and busy=done=0. Switch to mode=01 -> q=4'hF from the next edge.
- Repeat: write mem[0..2]=4'h1,4'h2,4'h4, len=3, mode=10 -> q=1,2,4,1,2,4,... with no gap. len=0 -> q=1 constantly. len=15 -> length clamped to 8.
- One-shot: mem[0..3]=A,B,C,D, len=4, mode=11, pulse start -> q=A,B,C,D,0. busy high for 4 cycles. done is a single pulse coincident with q returning to 0. A second start during busy is ignored.
- Back-to-back: start asserted on the done edge -> q=A,B,C,D,A,B,C,D,0 with exactly two done pulses.
- Collision/abort: write mem[1]=4'h9 on the same edge mem[1] is read -> q shows old value, and 4'h9 appears on the next lap. Switch from mode 11 to 00 mid-PLAY -> busy drops, no done, q=0.
- Async reset mid-PLAY -> q, busy, done drop immediately without waiting for clk. Memory then reads all zeros in mode 10.

Source files
------------

// File: rtl/lsmitll_pattern_src_sync.sv
// lsmitll_pattern_src_sync: clocked multi-channel constant / repeating / one-shot pattern source
module lsmitll_pattern_src_sync #(
    parameter int WIDTH  = 4,
    parameter int DEPTH  = 8,
    parameter int ADDR_W = $clog2(DEPTH),
    parameter int LEN_W  = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [1:0]        mode,
    input  logic [LEN_W-1:0]  len,
    input  logic              start,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [WIDTH-1:0]  wr_data,
    output logic [WIDTH-1:0]  q,
    output logic              busy,
    output logic              done
);
    typedef enum logic {IDLE, PLAY} state_t;

    localparam logic [LEN_W-1:0] DEPTH_L = LEN_W'(DEPTH);
    localparam logic [LEN_W-1:0] ONE_L   = LEN_W'(1);

    state_t           state_q, state_d;
    logic [LEN_W-1:0] ptr_q, ptr_d;
    logic [1:0]       mode_q;
    logic [WIDTH-1:0] q_q, q_d;
    logic             busy_q, busy_d, done_q, done_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [LEN_W-1:0] l, p;
    logic [WIDTH-1:0] rd;

    // ptr is one bit wider than an address so a one-shot can count past the last word
    assign l  = (len == '0) ? ONE_L : (len > DEPTH_L) ? DEPTH_L : len;
    assign p  = (mode != mode_q || ptr_q >= l) ? '0 : ptr_q;
    assign rd = mem_q[p[ADDR_W-1:0]];

    // next-state selection for all output modes and the one-shot FSM
    always_comb begin
        state_d = IDLE;
        ptr_d   = '0;
        q_d     = '0;
        busy_d  = 1'b0;
        done_d  = 1'b0;
        case (mode)
            2'b01: q_d = '1;
            2'b10: begin
                q_d   = rd;
                ptr_d = (p >= l - ONE_L) ? '0 : p + ONE_L;
            end
            2'b11: begin
                if (state_q == PLAY && ptr_q < l) begin
                    q_d     = rd;
                    ptr_d   = ptr_q + ONE_L;
                    busy_d  = 1'b1;
                    state_d = PLAY;
                end else begin
                    done_d = (state_q == PLAY);
                    if (start) begin
                        q_d     = mem_q[0];
                        ptr_d   = ONE_L;
                        busy_d  = 1'b1;
                        state_d = PLAY;
                    end
                end
            end
            default: ;
        endcase
    end

    // control and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            mode_q  <= 2'b00;
            q_q     <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            mode_q  <= mode;
            q_q     <= q_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    // pattern memory; non-blocking write gives read-before-write on a collision
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) mem_q <= '{default: '0};
        else if (wr_en) mem_q[wr_addr] <= wr_data;
    end

    assign q    = q_q;
    assign busy = busy_q;
    assign done = done_q;
endmodule
